quad_decoder: RTL
=================

# quad_decoder

Quadrature decoder converting a two-channel incremental encoder (A/B) into a direction level and a one-cycle count strobe. It sits directly upstream of the team's 4-bit up/down counter: `dir` drives the counter's direction input (1 = up), and `step` is the count-enable strobe. Raw pins are synchronised and glitch-filtered here. Illegal double transitions are flagged rather than counted.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flops per channel, legal range 2–4.
- `FILTER_LEN`, default 3: consecutive cycles a synchronised level must differ from the filtered level before it is accepted, legal range 1–15.
- `clk`  in  1  system clock; all flops on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `a_in`  in  1  raw encoder channel A, asynchronous to `clk`.
- `b_in`  in  1  raw encoder channel B, asynchronous to `clk`.
- `err_clr`  in  1  synchronous clear of `err_sticky`.
- `step`  out  1  one-cycle pulse per valid quadrature edge.
- `dir`  out  1  direction of the last valid edge, 1 = up, 0 = down.
- `err`  out  1  one-cycle pulse on an illegal transition.
- `err_sticky`  out  1  latched error flag.

## Operation
- Per channel: `SYNC_STAGES`-flop synchroniser, then a glitch filter.
  - The filter holds a counter of cycles where the synchronised level differs from the filtered level.
  - The counter is reset to 0 on any cycle where the two levels match.
  - The filtered level toggles on the edge where the counter would reach `FILTER_LEN`.
- Filtered pair `{a,b}` forms the phase state. Up sequence: 00→10→11→01→00. Down is the reverse.
- State machine `INIT` → `TRACK`:
  - `INIT`, entered on reset: the filters bypass counting and copy the synchronised level every cycle. A settle counter runs for `SYNC_STAGES+FILTER_LEN` cycles, then the machine moves to `TRACK` and loads `prev` from the filtered pair. No `step` or `err` is produced in `INIT`.
  - `TRACK`: compare filtered pair with `prev` each cycle, then update `prev`.
    - No change: no action.
    - One bit changed in the up direction: `step`=1, `dir`=1.
    - One bit changed in the down direction: `step`=1, `dir`=0.
    - Both bits changed (00↔11 or 10↔01): `err`=1, `step`=0, `dir` holds, `prev` still updates.
- `err_sticky`: set by `err`, cleared by `err_clr`; set wins when both occur in the same cycle.
- `dir` is a level and holds between steps.
- Reset mid-operation: all state returns to reset values immediately and the block re-enters `INIT`.

## Timing
- Reset values:
  - `step`=0, `err`=0, `err_sticky`=0, `dir`=1.
  - Synchronisers, filters and `prev` = 0.
  - State = `INIT`.
- Latency: a stable level change on `a_in` or `b_in` produces `step`/`err` `SYNC_STAGES+FILTER_LEN+1` rising edges later, i.e. 6 at defaults. `dir` updates on the same edge as `step`.
- Glitch rejection: a pulse shorter than `FILTER_LEN` cycles at synchroniser output is ignored.
- Maximum step rate: one step per `FILTER_LEN` cycles per channel. Faster input is undefined, but must not hang the FSM.
- `step` and `err` are registered outputs, never high together, never high for two consecutive cycles from a single input edge.
- Both filtered channels toggling on the same edge counts as an illegal transition (`err`), even if the raw edges were separated by less than the filter window.

## Structure
- Package `quad_pkg`:
  - `typedef enum logic {INIT, TRACK} quad_state_t`.
  - Phase constants `PH_00`, `PH_10`, `PH_11`, `PH_01`.
  - Function `quad_next_up(phase)` returning the successor phase in the up sequence.
- Sub-module `quad_filter`: synchroniser plus glitch filter plus `bypass` input, parameterised by `SYNC_STAGES`/`FILTER_LEN`, instantiated once per channel.
- Top level holds the FSM, settle counter, phase compare and error latch.

## Test plan
- Reset with A=B=0, then drive up sequence 00→10→11→01→00, each phase held 10 cycles → 4 `step` pulses, `dir`=1, each 6 cycles after its input edge, `err`=0.
- Same sequence reversed after an up run → 4 `step` pulses with `dir`=0 from the first reversed edge; `dir` stays 0 afterwards.
- 2-cycle glitch on `a_in` (FILTER_LEN=3) while B static → no `step`, no `err`, `dir` unchanged.
- Jump 00→11 in one cycle → one `err` pulse, no `step`, `err_sticky`=1. Assert `err_clr` on the same cycle as a second 10→01 error → `err_sticky` stays 1. `err_clr` alone → `err_sticky`=0.
- Release reset with A=B=1 → no `step`/`err` during or after `INIT`. Next edge 11→01 → `step`=1, `dir`=1.
- Assert `reset` mid-sequence while `step` is due → outputs at reset values immediately. Recovery through `INIT` with no spurious pulse.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and phase helpers for the quadrature decoder.
// Phase encoding is the filtered pair {a,b}; up order is 00 -> 10 -> 11 -> 01 -> 00.
package quad_pkg;

   typedef enum logic {INIT, TRACK} quad_state_t;

   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_10 = 2'b10;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_01 = 2'b01;

   function automatic logic [1:0] quad_next_up(input logic [1:0] phase);
      logic [1:0] nxt;
      case (phase)
         PH_00:   nxt = PH_10;
         PH_10:   nxt = PH_11;
         PH_11:   nxt = PH_01;
         default: nxt = PH_00;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder pins, error clear and decoded outputs of the quadrature decoder.
// master drives the pins and clear; slave is the decoder.
interface quad_decoder_if;
   logic a_in;
   logic b_in;
   logic err_clr;
   logic step;
   logic dir;
   logic err;
   logic err_sticky;

   modport master (output a_in, b_in, err_clr, input step, dir, err, err_sticky);
   modport slave  (input a_in, b_in, err_clr, output step, dir, err, err_sticky);
endinterface

// File: rtl/quad_filter.sv
// Per-channel synchroniser and glitch filter; level moves SYNC_STAGES+FILTER_LEN edges after a stable pin change.
// bypass makes the filter track the synchronised level directly (used while settling).
module quad_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   input  logic bypass,
   output logic dout
);

   localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [3:0]             cnt_q;
   logic                   sync_lvl;

   assign sync_lvl = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      end
   end

   // Counter holds mismatch cycles so far; the cycle that would make it FILTER_LEN flips the level instead.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout  <= 1'b0;
         cnt_q <= '0;
      end else if (bypass) begin
         dout  <= sync_lvl;
         cnt_q <= '0;
      end else if (sync_lvl == dout) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
         dout  <= sync_lvl;
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 4'd1;
      end
   end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B phase tracking into dir level, step strobe and error flags.
// step/err appear SYNC_STAGES+FILTER_LEN+1 edges after a stable pin change; err_sticky follows err by one cycle.
module quad_decoder
   import quad_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic          clk,
   input  logic          reset,
   quad_decoder_if.slave bus
);

   localparam logic [4:0] SETTLE_LAST = 5'(SYNC_STAGES + FILTER_LEN - 1);

   quad_state_t state_q, state_d;
   logic [4:0]  settle_q, settle_d;
   logic [1:0]  prev_q, prev_d;
   logic        step_q, step_d;
   logic        err_q, err_d;
   logic        dir_q, dir_d;
   logic        sticky_q, sticky_d;
   logic        filt_a, filt_b;
   logic        bypass;
   logic [1:0]  phase;

   assign bypass = (state_q == INIT);
   assign phase  = {filt_a, filt_b};

   quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
      .clk    (clk),
      .reset  (reset),
      .din    (bus.a_in),
      .bypass (bypass),
      .dout   (filt_a)
   );

   quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
      .clk    (clk),
      .reset  (reset),
      .din    (bus.b_in),
      .bypass (bypass),
      .dout   (filt_b)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= INIT;
         settle_q <= '0;
         prev_q   <= PH_00;
         step_q   <= 1'b0;
         err_q    <= 1'b0;
         dir_q    <= 1'b1;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         prev_q   <= prev_d;
         step_q   <= step_d;
         err_q    <= err_d;
         dir_q    <= dir_d;
         sticky_q <= sticky_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      prev_d   = prev_q;
      step_d   = 1'b0;
      err_d    = 1'b0;
      dir_d    = dir_q;
      case (state_q)
         INIT: begin
            if (settle_q == SETTLE_LAST) begin
               state_d  = TRACK;
               settle_d = '0;
               prev_d   = phase;
            end else begin
               settle_d = settle_q + 5'd1;
            end
         end
         TRACK: begin
            prev_d = phase;
            if (phase != prev_q) begin
               if (phase == quad_next_up(prev_q)) begin
                  step_d = 1'b1;
                  dir_d  = 1'b1;
               end else if (prev_q == quad_next_up(phase)) begin
                  step_d = 1'b1;
                  dir_d  = 1'b0;
               end else begin
                  // Both channels moved at once: direction is unknowable, so flag and resync.
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = INIT;
      endcase
      sticky_d = err_q | (sticky_q & ~bus.err_clr);
   end

   assign bus.step       = step_q;
   assign bus.err        = err_q;
   assign bus.dir        = dir_q;
   assign bus.err_sticky = sticky_q;

endmodule
